// File: rtl/vm_pkg.sv
// vm_pkg: shared state encoding, coin defaults and price/coin helpers for the vending controller.
package vm_pkg;
  typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;
  localparam int COIN_A_DEF = 5;
  localparam int COIN_B_DEF = 10;
  function automatic int price_at(input logic [127:0] prices, input int idx, input int w);
    logic [127:0] mask;
    mask = (128'd1 << w) - 128'd1;
    return int'((prices >> (idx * w)) & mask);
  endfunction
  // Largest coin not exceeding v; returns v itself when v is below the small coin.
  function automatic int coin_of(input int v, input int a, input int b);
    return v >= b ? b : v >= a ? a : v;
  endfunction
endpackage

// File: rtl/vm_change_dispenser.sv
// vm_change_dispenser: holds outstanding change and returns one coin per cycle.
module vm_change_dispenser
  import vm_pkg::*;
#(
  parameter int AMT_W    = 4,
  parameter int CREDIT_W = 6,
  parameter int COIN_A   = COIN_A_DEF,
  parameter int COIN_B   = COIN_B_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [CREDIT_W-1:0] load_val,
  output logic [AMT_W-1:0]    change,
  output logic [CREDIT_W-1:0] rem_next,
  output logic                done
);
  logic [CREDIT_W-1:0] rem, src, coin;
  always_comb begin
    src = load ? load_val : rem;
    coin = CREDIT_W'(coin_of(int'(src), COIN_A, COIN_B));
    rem_next = src - coin;
  end
  assign done = rem == '0;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem <= '0;
      change <= '0;
    end else begin
      rem <= rem_next;
      change <= AMT_W'(coin);
    end
  end
endmodule

// File: rtl/vending_machine_multi.sv
// vending_machine_multi: multi-item vending controller with saturating credit, stock and multi-cycle change.
module vending_machine_multi
  import vm_pkg::*;
#(
  parameter int NUM_ITEMS  = 4,
  parameter int AMT_W      = 4,
  parameter int CREDIT_W   = 6,
  parameter int COIN_A     = COIN_A_DEF,
  parameter int COIN_B     = COIN_B_DEF,
  parameter int MAX_CREDIT = 30,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES = {6'd15, 6'd20, 6'd10, 6'd25},
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 3,
  localparam int IW        = $clog2(NUM_ITEMS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [AMT_W-1:0]     amt,
  input  logic                 sel_valid,
  input  logic [IW-1:0]        sel_id,
  input  logic                 cancel,
  output logic                 item,
  output logic [IW-1:0]        item_id,
  output logic [AMT_W-1:0]     change,
  output logic                 coin_reject,
  output logic                 err,
  output logic [CREDIT_W-1:0]  credit,
  output logic                 busy,
  output logic [NUM_ITEMS-1:0] sold_out
);
  state_t state, state_n;
  logic [CREDIT_W-1:0] credit_n, price, rem_next;
  logic [CREDIT_W:0] sum;
  logic [STOCK_W-1:0] stock [NUM_ITEMS];
  logic open, sel_ok, take_sel, sel_err, do_cancel, coin_ok, load, done;
  vm_change_dispenser #(
    .AMT_W(AMT_W), .CREDIT_W(CREDIT_W), .COIN_A(COIN_A), .COIN_B(COIN_B)
  ) u_disp (
    .clk(clk), .reset(reset), .load(load), .load_val(credit),
    .change(change), .rem_next(rem_next), .done(done)
  );
  // Selection and coin decisions use the registered credit; cancel overrides selection.
  always_comb begin
    open = state == IDLE || state == CREDIT;
    price = CREDIT_W'(price_at(128'(PRICES), int'(sel_id), CREDIT_W));
    sum = {1'b0, credit} + (CREDIT_W+1)'(amt);
    do_cancel = state == CREDIT && cancel;
    sel_ok = int'(sel_id) < NUM_ITEMS && stock[sel_id] != '0 && credit >= price;
    take_sel = open && sel_valid && !cancel && sel_ok;
    sel_err = open && sel_valid && !cancel && !sel_ok;
    coin_ok = open && !take_sel && !do_cancel && (amt == AMT_W'(COIN_A) || amt == AMT_W'(COIN_B))
              && sum <= (CREDIT_W+1)'(MAX_CREDIT);
    load = do_cancel || (state == VEND && credit != '0);
    state_n = state;
    credit_n = credit;
    if (do_cancel) begin
      state_n = CHANGE;
      credit_n = rem_next;
    end else if (take_sel) begin
      state_n = VEND;
      credit_n = credit - price;
    end else if (coin_ok) begin
      state_n = CREDIT;
      credit_n = sum[CREDIT_W-1:0];
    end else if (state == VEND) begin
      state_n = load ? CHANGE : IDLE;
      credit_n = rem_next;
    end else if (state == CHANGE) begin
      state_n = done ? IDLE : CHANGE;
      credit_n = rem_next;
    end
  end
  always_comb begin
    sold_out = '0;
    for (int i = 0; i < NUM_ITEMS; i++) sold_out[i] = stock[i] == '0;
  end
  assign busy = state == VEND || state == CHANGE;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      credit <= '0;
      item <= 1'b0;
      item_id <= '0;
      coin_reject <= 1'b0;
      err <= 1'b0;
      for (int i = 0; i < NUM_ITEMS; i++) stock[i] <= STOCK_W'(STOCK_INIT);
    end else begin
      state <= state_n;
      credit <= credit_n;
      item <= take_sel;
      item_id <= take_sel ? sel_id : item_id;
      coin_reject <= amt != '0 && !coin_ok;
      err <= sel_err;
      if (take_sel) stock[sel_id] <= stock[sel_id] - STOCK_W'(1);
    end
  end
endmodule

// File: tb/tb_vending_machine_multi.sv
// tb_vending_machine_multi: directed scoreboard bench for vending_machine_multi (default parameters).
module tb_vending_machine_multi;
  logic clk = 1'b0, reset = 1'b0, sel_valid = 1'b0, cancel = 1'b0;
  logic [3:0] amt = '0;
  logic [1:0] sel_id = '0;
  logic item, coin_reject, err, busy;
  logic [1:0] item_id;
  logic [3:0] change, sold_out;
  logic [5:0] credit;
  int checks = 0, errors = 0;

  typedef struct packed {
    logic item; logic [1:0] id; logic [3:0] chg; logic rej; logic err;
    logic [5:0] cr; logic busy; logic [3:0] so;
  } obs_t;
  obs_t q[$];

  vending_machine_multi dut (
    .clk(clk), .reset(reset), .amt(amt), .sel_valid(sel_valid), .sel_id(sel_id),
    .cancel(cancel), .item(item), .item_id(item_id), .change(change),
    .coin_reject(coin_reject), .err(err), .credit(credit), .busy(busy), .sold_out(sold_out)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic obs_t mk(input logic it, input logic [1:0] id, input logic [3:0] chg,
                              input logic rej, input logic er, input logic [5:0] cr,
                              input logic bz, input logic [3:0] so);
    return '{it, id, chg, rej, er, cr, bz, so};
  endfunction

  task automatic check(input string tag, input obs_t exp);
    obs_t act;
    act = '{item, item ? item_id : 2'b0, change, coin_reject, err, credit, busy, sold_out};
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, act, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the response expected in the following cycle, then compare it.
  task automatic step(input string tag, input logic [3:0] a, input logic sv, input logic [1:0] sid,
                      input logic cn, input obs_t exp);
    amt = a; sel_valid = sv; sel_id = sid; cancel = cn;
    q.push_back(exp);
    @(posedge clk);
    #1;
    amt = '0; sel_valid = 1'b0; cancel = 1'b0;
    check(tag, q.pop_front());
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset", mk(0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b1;
    // 5,10 then item 3 (price 15): exact credit, no change
    step("c5", 5, 0, 0, 0, mk(0, 0, 0, 0, 0, 5, 0, 0));
    step("c10", 10, 0, 0, 0, mk(0, 0, 0, 0, 0, 15, 0, 0));
    step("vend3", 0, 1, 3, 0, mk(1, 3, 0, 0, 0, 0, 1, 0));
    step("idle1", 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0));
    // 10,10 then item 3: one 5 coin of change
    step("c10a", 10, 0, 0, 0, mk(0, 0, 0, 0, 0, 10, 0, 0));
    step("c10b", 10, 0, 0, 0, mk(0, 0, 0, 0, 0, 20, 0, 0));
    step("vend3b", 0, 1, 3, 0, mk(1, 3, 0, 0, 0, 5, 1, 0));
    step("chg5", 0, 0, 0, 0, mk(0, 0, 5, 0, 0, 0, 1, 0));
    step("idle2", 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0));
    // 10,10,5 then cancel: 10,10,5 returned, coin during change rejected
    step("c10c", 10, 0, 0, 0, mk(0, 0, 0, 0, 0, 10, 0, 0));
    step("c10d", 10, 0, 0, 0, mk(0, 0, 0, 0, 0, 20, 0, 0));
    step("c5b", 5, 0, 0, 0, mk(0, 0, 0, 0, 0, 25, 0, 0));
    step("cancel", 0, 0, 0, 1, mk(0, 0, 10, 0, 0, 15, 1, 0));
    step("chg_busy_coin", 5, 0, 0, 0, mk(0, 0, 10, 1, 0, 5, 1, 0));
    step("chg_last", 0, 0, 0, 0, mk(0, 0, 5, 0, 0, 0, 1, 0));
    step("idle3", 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0));
    // bad coin, credit ceiling
    step("bad_coin", 7, 0, 0, 0, mk(0, 0, 0, 1, 0, 0, 0, 0));
    step("m10", 10, 0, 0, 0, mk(0, 0, 0, 0, 0, 10, 0, 0));
    step("m20", 10, 0, 0, 0, mk(0, 0, 0, 0, 0, 20, 0, 0));
    step("m30", 10, 0, 0, 0, mk(0, 0, 0, 0, 0, 30, 0, 0));
    step("over_max", 5, 0, 0, 0, mk(0, 0, 0, 1, 0, 30, 0, 0));
    step("cancel30", 0, 0, 0, 1, mk(0, 0, 10, 0, 0, 20, 1, 0));
    step("chg30b", 0, 0, 0, 0, mk(0, 0, 10, 0, 0, 10, 1, 0));
    step("chg30c", 0, 0, 0, 0, mk(0, 0, 10, 0, 0, 0, 1, 0));
    step("idle4", 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0));
    // insufficient credit, then accepted selection with a simultaneous coin
    step("p10", 10, 0, 0, 0, mk(0, 0, 0, 0, 0, 10, 0, 0));
    step("p20", 10, 0, 0, 0, mk(0, 0, 0, 0, 0, 20, 0, 0));
    step("short_credit", 0, 1, 0, 0, mk(0, 0, 0, 0, 1, 20, 0, 0));
    step("vend2_coin", 5, 1, 2, 0, mk(1, 2, 0, 1, 0, 0, 1, 0));
    step("idle5", 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0));
    // drain item 2 (stock 3) and confirm sold-out refusal keeps credit
    step("s1a", 10, 0, 0, 0, mk(0, 0, 0, 0, 0, 10, 0, 0));
    step("s1b", 10, 0, 0, 0, mk(0, 0, 0, 0, 0, 20, 0, 0));
    step("s1v", 0, 1, 2, 0, mk(1, 2, 0, 0, 0, 0, 1, 0));
    step("s1i", 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0));
    step("s2a", 10, 0, 0, 0, mk(0, 0, 0, 0, 0, 10, 0, 0));
    step("s2b", 10, 0, 0, 0, mk(0, 0, 0, 0, 0, 20, 0, 0));
    step("s2v", 0, 1, 2, 0, mk(1, 2, 0, 0, 0, 0, 1, 4'b0100));
    step("s2i", 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 4'b0100));
    step("s3a", 10, 0, 0, 0, mk(0, 0, 0, 0, 0, 10, 0, 4'b0100));
    step("s3b", 10, 0, 0, 0, mk(0, 0, 0, 0, 0, 20, 0, 4'b0100));
    step("sold_out_err", 0, 1, 2, 0, mk(0, 0, 0, 0, 1, 20, 0, 4'b0100));
    // cancel and select together: cancel wins, no err
    step("cancel_sel", 0, 1, 1, 1, mk(0, 0, 10, 0, 0, 10, 1, 4'b0100));
    step("cs_b", 0, 0, 0, 0, mk(0, 0, 10, 0, 0, 0, 1, 4'b0100));
    step("cs_idle", 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 4'b0100));
    // reset during second change cycle
    step("r10", 10, 0, 0, 0, mk(0, 0, 0, 0, 0, 10, 0, 4'b0100));
    step("r20", 10, 0, 0, 0, mk(0, 0, 0, 0, 0, 20, 0, 4'b0100));
    step("r25", 5, 0, 0, 0, mk(0, 0, 0, 0, 0, 25, 0, 4'b0100));
    step("r_cancel", 0, 0, 0, 1, mk(0, 0, 10, 0, 0, 15, 1, 4'b0100));
    step("r_chg2", 0, 0, 0, 0, mk(0, 0, 10, 0, 0, 5, 1, 4'b0100));
    #2 reset = 1'b0;
    #1 check("async_reset", mk(0, 0, 0, 0, 0, 0, 0, 0));
    #2 reset = 1'b1;
    step("post_reset", 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0));
    step("rl10", 10, 0, 0, 0, mk(0, 0, 0, 0, 0, 10, 0, 0));
    step("rl20", 10, 0, 0, 0, mk(0, 0, 0, 0, 0, 20, 0, 0));
    step("reload_vend2", 0, 1, 2, 0, mk(1, 2, 0, 0, 0, 0, 1, 0));
    step("rl_idle", 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
